// File: rtl/uart_mmio_if.sv
// uart_mmio_if: MEM-stage data bus as seen by the UART.
interface uart_mmio_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   modport master (output rd, wr, addr, wdata, input rdata);
   modport slave (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with TXD/RXD/CON registers and a level interrupt.
module uart_mmio #(
   parameter int          DIV  = 326,
   parameter logic [31:0] BASE = 32'h4000_0018
) (
   input  logic        clk,
   input  logic        reset,
   uart_mmio_if.slave  bus,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq
);
   localparam int BT = 16 * DIV;
   localparam int CW = $clog2(BT);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
   state_t tx_state, tx_next, rx_state, rx_next;
   logic [CW-1:0] tx_cnt, rx_cnt;
   logic [2:0] tx_bit, rx_bit;
   logic [7:0] tx_sh, rx_sh, rx_data;
   logic tx_done, rx_valid, rx_ovr, ferr, irq_en, s1, s2;
   logic a_txd, a_rxd, a_con, rd_rxd, rd_con, tx_busy;
   logic tx_load, tx_tick, tx_fin, rx_tick, rx_half, rx_ok, rx_bad;
   logic unused_wdata;
   assign unused_wdata = ^bus.wdata[31:8];
   assign a_txd = bus.addr == BASE;
   assign a_rxd = bus.addr == BASE + 32'd4;
   assign a_con = bus.addr == BASE + 32'd8;
   assign rd_rxd = bus.rd && a_rxd;
   assign rd_con = bus.rd && a_con;
   assign tx_busy = tx_state != IDLE;
   assign bus.rdata = !bus.rd ? '0 : a_rxd ? {24'b0, rx_data} :
                      a_con ? {26'b0, ferr, irq_en, rx_ovr, tx_busy, rx_valid, tx_done} : '0;
   assign irq = irq_en & (rx_valid | tx_done);
   assign tx_load = bus.wr && a_txd && !tx_busy;
   assign tx_tick = tx_cnt == CW'(BT - 1);
   assign tx_fin = tx_state == STOP && tx_tick;
   assign uart_tx = tx_state == START ? 1'b0 : tx_state == DATA ? tx_sh[0] : 1'b1;
   always_ff @(posedge clk or negedge reset)
      if (!reset) tx_state <= IDLE;
      else tx_state <= tx_next;
   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         IDLE:    tx_next = tx_load ? START : IDLE;
         START:   tx_next = tx_tick ? DATA : START;
         DATA:    tx_next = tx_tick && tx_bit == 3'd7 ? STOP : DATA;
         STOP:    tx_next = tx_tick ? IDLE : STOP;
         default: tx_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_sh  <= '0;
      end else begin
         tx_cnt <= (!tx_busy || tx_tick) ? '0 : tx_cnt + 1'b1;
         tx_bit <= tx_state != DATA ? 3'd0 : tx_tick ? tx_bit + 3'd1 : tx_bit;
         if (tx_load) tx_sh <= bus.wdata[7:0];
         else if (tx_state == DATA && tx_tick) tx_sh <= tx_sh >> 1;
      end
   // s1/s2 reset high so the idle line is not mistaken for a start bit
   always_ff @(posedge clk or negedge reset)
      if (!reset) {s1, s2} <= 2'b11;
      else {s1, s2} <= {uart_rx, s1};
   assign rx_tick = rx_cnt == CW'(BT - 1);
   assign rx_half = rx_cnt == CW'(BT / 2 - 1);
   assign rx_ok = rx_state == STOP && rx_tick && s2;
   assign rx_bad = rx_state == STOP && rx_tick && !s2;
   always_ff @(posedge clk or negedge reset)
      if (!reset) rx_state <= IDLE;
      else rx_state <= rx_next;
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         IDLE:    rx_next = !s2 ? START : IDLE;
         START:   rx_next = !rx_half ? START : s2 ? IDLE : DATA;
         DATA:    rx_next = rx_tick && rx_bit == 3'd7 ? STOP : DATA;
         STOP:    rx_next = !rx_tick ? STOP : s2 ? IDLE : BRK;
         BRK:     rx_next = s2 ? IDLE : BRK;
         default: rx_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rx_cnt <= '0;
         rx_bit <= '0;
         rx_sh  <= '0;
      end else begin
         rx_cnt <= (rx_state == IDLE || rx_state == BRK || (rx_state == START && rx_half) || rx_tick)
                   ? '0 : rx_cnt + 1'b1;
         rx_bit <= rx_state != DATA ? 3'd0 : rx_tick ? rx_bit + 3'd1 : rx_bit;
         if (rx_state == DATA && rx_tick) rx_sh <= {s2, rx_sh[7:1]};
      end
   // new events take priority over the clears caused by reads in the same cycle
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         tx_done  <= 1'b0;
         rx_valid <= 1'b0;
         rx_ovr   <= 1'b0;
         ferr     <= 1'b0;
         irq_en   <= 1'b0;
         rx_data  <= '0;
      end else begin
         tx_done  <= tx_fin | (tx_done & !rd_con);
         rx_valid <= rx_ok | (rx_valid & !rd_rxd);
         rx_ovr   <= (rx_ok & rx_valid & !rd_rxd) | (rx_ovr & !rd_con);
         ferr     <= rx_bad | (ferr & !rd_con);
         if (bus.wr && a_con) irq_en <= bus.wdata[4];
         if (rx_ok) rx_data <= rx_sh;
      end
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: register vectors, directed frame sequences and randomized RX/TX
// traffic checked against a byte-level model of the UART (DIV=4, 64 clocks/bit).
module tb_uart_mmio;
   localparam logic [31:0] TXD = 32'h4000_0018;
   localparam logic [31:0] RXD = 32'h4000_001C;
   localparam logic [31:0] CON = 32'h4000_0020;
   localparam int BT = 64;
   logic clk = 1'b0, reset = 1'b0, uart_rx = 1'b1;
   logic uart_tx, irq;
   int total = 0, bad = 0;
   uart_mmio_if b ();
   uart_mmio #(.DIV(4)) dut (.clk(clk), .reset(reset), .bus(b), .uart_rx(uart_rx),
                            .uart_tx(uart_tx), .irq(irq));
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vt[16];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      b.wr = 1'b1; b.addr = a; b.wdata = d;
      @(negedge clk);
      b.wr = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      b.rd = 1'b1; b.addr = a;
      #1 d = b.rdata;
      @(negedge clk);
      b.rd = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] want);
      logic [31:0] d;
      bus_read(a, d);
      check(name, d, want);
   endtask

   // Called at the first negedge after the TXD write edge; samples all 640 clocks.
   task automatic tx_monitor(input logic [7:0] v, input string name);
      for (int i = 0; i < 10; i++) begin
         logic want, got;
         want = i == 0 ? 1'b0 : i == 9 ? 1'b1 : v[i-1];
         got = want;
         for (int c = 0; c < BT; c++) begin
            if (uart_tx !== want) got = uart_tx;
            @(negedge clk);
         end
         check($sformatf("%s bit%0d", name, i), {31'b0, got}, {31'b0, want});
      end
   endtask

   task automatic send_frame(input logic [7:0] v, input logic stop);
      uart_rx = 1'b0;
      repeat (BT) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         uart_rx = v[k];
         repeat (BT) @(negedge clk);
      end
      uart_rx = stop;
      repeat (BT) @(negedge clk);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0] m_data, rb;
      logic m_valid, m_ovr, m_ferr, stop;
      b.rd = 1'b0; b.wr = 1'b0; b.addr = '0; b.wdata = '0;
      vt[0]  = '{1'b1, 1'b0, CON, 32'h0, 32'h0};
      vt[1]  = '{1'b0, 1'b1, CON, 32'h10, 32'h0};
      vt[2]  = '{1'b1, 1'b0, CON, 32'h0, 32'h10};
      vt[3]  = '{1'b0, 1'b0, CON, 32'h0, 32'h0};
      vt[4]  = '{1'b1, 1'b0, 32'h4000_0024, 32'h0, 32'h0};
      vt[5]  = '{1'b1, 1'b0, TXD, 32'h0, 32'h0};
      vt[6]  = '{1'b0, 1'b1, RXD, 32'hFF, 32'h0};
      vt[7]  = '{1'b1, 1'b0, RXD, 32'h0, 32'h0};
      vt[8]  = '{1'b0, 1'b1, CON, 32'hFFFF_FFEF, 32'h0};
      vt[9]  = '{1'b1, 1'b0, CON, 32'h0, 32'h0};
      vt[10] = '{1'b1, 1'b0, 32'h4000_0014, 32'h0, 32'h0};
      vt[11] = '{1'b1, 1'b0, 32'hC000_0020, 32'h0, 32'h0};
      vt[12] = '{1'b0, 1'b1, CON, 32'h3F, 32'h0};
      vt[13] = '{1'b1, 1'b0, CON, 32'h0, 32'h10};
      vt[14] = '{1'b0, 1'b1, CON, 32'h0, 32'h0};
      vt[15] = '{1'b1, 1'b0, CON, 32'h0, 32'h0};
      repeat (3) @(negedge clk);
      check("reset tx", {31'b0, uart_tx}, 32'h1);
      reset = 1'b1;
      @(negedge clk);
      check("release tx", {31'b0, uart_tx}, 32'h1);
      check("release irq", {31'b0, irq}, 32'h0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         b.rd = vt[i].rd; b.wr = vt[i].wr; b.addr = vt[i].addr; b.wdata = vt[i].wdata;
         #1 check($sformatf("vec%0d", i), b.rdata, vt[i].exp);
         @(negedge clk);
         b.rd = 1'b0; b.wr = 1'b0;
      end
      check("vec irq", {31'b0, irq}, 32'h0);

      bus_write(TXD, 32'hA5);
      tx_monitor(8'hA5, "txA5");
      read_check("txA5 con", CON, 32'h01);
      read_check("txA5 con2", CON, 32'h00);

      bus_write(TXD, 32'h55);
      fork
         tx_monitor(8'h55, "tx55");
         begin
            repeat (9) @(negedge clk);
            bus_write(TXD, 32'h0F);
            repeat (627) @(negedge clk);
            read_check("busy@639", CON, 32'h04);
            read_check("done@641", CON, 32'h01);
         end
      join
      d = 32'h1;
      for (int c = 0; c < 200; c++) begin
         if (uart_tx !== 1'b1) d = 32'h0;
         @(negedge clk);
      end
      check("dropped frame idle", d, 32'h1);

      bus_write(CON, 32'h10);
      fork
         send_frame(8'h3C, 1'b1);
         begin
            repeat (610) @(negedge clk);
            check("irq@610", {31'b0, irq}, 32'h0);
            @(negedge clk);
            check("irq@611", {31'b0, irq}, 32'h1);
         end
      join
      read_check("rx3C", RXD, 32'h3C);
      check("irq after rxd", {31'b0, irq}, 32'h0);

      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      read_check("ovr con", CON, 32'h1A);
      read_check("ovr rxd", RXD, 32'h22);
      read_check("ovr con2", CON, 32'h10);

      send_frame(8'h5A, 1'b1);
      send_frame(8'h77, 1'b0);
      read_check("ferr con", CON, 32'h32);
      read_check("ferr rxd", RXD, 32'h5A);

      uart_rx = 1'b0;
      repeat (20) @(negedge clk);
      uart_rx = 1'b1;
      repeat (200) @(negedge clk);
      read_check("glitch con", CON, 32'h10);
      read_check("glitch rxd", RXD, 32'h5A);

      m_data = 8'h5A; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
      for (int it = 0; it < 8; it++) begin
         rb = 8'($urandom);
         stop = $urandom_range(0, 3) != 0;
         send_frame(rb, stop);
         if (stop) begin
            m_ovr = m_ovr | m_valid;
            m_valid = 1'b1;
            m_data = rb;
         end else m_ferr = 1'b1;
         if ($urandom_range(0, 1) == 1) begin
            read_check($sformatf("rnd%0d rxd", it), RXD, {24'b0, m_data});
            m_valid = 1'b0;
         end
         if (it % 2 == 1) begin
            read_check($sformatf("rnd%0d con", it), CON,
                       {26'b0, m_ferr, 1'b1, m_ovr, 1'b0, m_valid, 1'b0});
            m_ovr = 1'b0; m_ferr = 1'b0;
         end
      end
      read_check("rnd rxd final", RXD, {24'b0, m_data});
      read_check("rnd con final", CON, 32'h10);

      for (int it = 0; it < 3; it++) begin
         rb = 8'($urandom);
         bus_write(TXD, {24'b0, rb});
         tx_monitor(rb, $sformatf("rndtx%0d", it));
         check($sformatf("rndtx%0d irq", it), {31'b0, irq}, 32'h1);
         read_check($sformatf("rndtx%0d con", it), CON, 32'h11);
      end

      bus_write(TXD, 32'h00);
      repeat (280) @(negedge clk);
      check("bit3 low", {31'b0, uart_tx}, 32'h0);
      #2 reset = 1'b0;
      #1 check("reset mid tx", {31'b0, uart_tx}, 32'h1);
      check("reset mid irq", {31'b0, irq}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      read_check("post reset con", CON, 32'h0);
      bus_write(TXD, 32'hC3);
      tx_monitor(8'hC3, "txC3");
      read_check("txC3 con", CON, 32'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
